// File: rtl/paillier_encry_ctrl_pkg.sv
// Shared definitions for the Paillier encryption controller: default widths and FSM encoding.
package paillier_encry_ctrl_pkg;

   localparam int unsigned DefRsaWidth  = 4096;
   localparam int unsigned DefDataWidth = 128;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StGm,
      StWaitExp,
      StMul,
      StWaitMul,
      StDone
   } state_e;

endpackage

// File: rtl/paillier_encry_ctrl_shift_add_mul.sv
// Sequential N_WIDTH x N_WIDTH shift-add multiplier, MSB of a first, one bit per cycle.
// Operands a and b are read live and must stay stable from start until done.
// done pulses for one cycle once product holds a*b.
module paillier_shift_add_mul
   import paillier_encry_ctrl_pkg::*;
#(
   parameter int unsigned N_WIDTH = DefRsaWidth / 2,
   parameter int unsigned P_WIDTH = 2 * N_WIDTH
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [N_WIDTH-1:0] a,
   input  logic [N_WIDTH-1:0] b,
   output logic [P_WIDTH-1:0] product,
   output logic               done
);

   localparam int unsigned CntW = (N_WIDTH > 1) ? $clog2(N_WIDTH) : 1;

   logic [P_WIDTH-1:0] acc_q, acc_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic               run_q, run_d;
   logic               done_q, done_d;
   logic [P_WIDTH-1:0] addend;

   // Next-state: clear on start, then one shift-add step per cycle until bit 0 is consumed.
   always_comb begin
      acc_d  = acc_q;
      cnt_d  = cnt_q;
      run_d  = run_q;
      done_d = 1'b0;
      addend = a[cnt_q] ? {{(P_WIDTH-N_WIDTH){1'b0}}, b} : '0;
      if (start) begin
         acc_d = '0;
         cnt_d = CntW'(N_WIDTH - 1);
         run_d = 1'b1;
      end else if (run_q) begin
         acc_d = (acc_q << 1) + addend;
         if (cnt_q == '0) begin
            run_d  = 1'b0;
            done_d = 1'b1;
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q  <= '0;
         cnt_q  <= '0;
         run_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         cnt_q  <= cnt_d;
         run_q  <= run_d;
         done_q <= done_d;
      end
   end

   assign product = acc_q;
   assign done    = done_q;

endmodule

// File: rtl/paillier_encry_ctrl.sv
// Paillier encryption controller: c = (1 + m*n) * r^n mod n^2.
// m*n comes from a local shift-add multiplier; r^n mod n^2 and the final product come from
// shared external modexp / modmul engines via go/done handshakes.
// Optional build macro PAILLIER_RANGE_CHECK_EN adds an err output and rejects m >= n or r == 0.
module paillier_encry_ctrl
   import paillier_encry_ctrl_pkg::*;
#(
   parameter int unsigned RSA_WIDTH  = DefRsaWidth,
   parameter int unsigned N_WIDTH    = RSA_WIDTH / 2,
   parameter int unsigned DATA_WIDTH = DefDataWidth
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 go,
   input  logic [N_WIDTH-1:0]   m,
   input  logic [N_WIDTH-1:0]   r,
   input  logic [N_WIDTH-1:0]   n,
   input  logic [RSA_WIDTH-1:0] exp_n,
   output logic [RSA_WIDTH-1:0] result,
   output logic                 done,
   output logic                 busy,
`ifdef PAILLIER_RANGE_CHECK_EN
   output logic                 err,
`endif
   output logic                 exp_go,
   output logic [RSA_WIDTH-1:0] exp_base,
   output logic [RSA_WIDTH-1:0] exp_exponent,
   output logic [RSA_WIDTH-1:0] exp_modulus,
   input  logic                 exp_done,
   input  logic [RSA_WIDTH-1:0] exp_result,
   output logic                 mul_go,
   output logic [RSA_WIDTH-1:0] mul_a,
   output logic [RSA_WIDTH-1:0] mul_b,
   output logic [RSA_WIDTH-1:0] mul_modulus,
   input  logic                 mul_done,
   input  logic [RSA_WIDTH-1:0] mul_result
);

   // DATA_WIDTH only sizes the shared engines; nothing in this block depends on it.
   if (DATA_WIDTH == 0) begin : g_data_width_unused
   end

   state_e               state_q, state_d;
   logic [N_WIDTH-1:0]   m_q, m_d, r_q, r_d, n_q, n_d;
   logic [RSA_WIDTH-1:0] nsq_q, nsq_d;
   logic [RSA_WIDTH-1:0] acc_q, acc_d;
   logic [RSA_WIDTH-1:0] exp_q, exp_d;
   logic                 exp_ok_q, exp_ok_d;
   logic [RSA_WIDTH-1:0] result_q, result_d;
   logic                 range_bad;
   logic                 sam_start, sam_done;
   logic [RSA_WIDTH-1:0] sam_product;
`ifdef PAILLIER_RANGE_CHECK_EN
   logic                 err_q, err_d;

   assign range_bad = (m_q >= n_q) || (r_q == '0);
   assign err       = err_q;
`else
   assign range_bad = 1'b0;
`endif

   assign sam_start = (state_q == StLoad) && !range_bad;

   paillier_shift_add_mul #(
      .N_WIDTH (N_WIDTH),
      .P_WIDTH (RSA_WIDTH)
   ) u_gm_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (sam_start),
      .a       (m_q),
      .b       (n_q),
      .product (sam_product),
      .done    (sam_done)
   );

   // Next-state and datapath: operand capture, sticky modexp result, FSM sequencing.
   always_comb begin
      state_d  = state_q;
      m_d      = m_q;
      r_d      = r_q;
      n_d      = n_q;
      nsq_d    = nsq_q;
      acc_d    = acc_q;
      exp_d    = exp_q;
      exp_ok_d = exp_ok_q;
      result_d = result_q;
`ifdef PAILLIER_RANGE_CHECK_EN
      err_d    = err_q;
`endif
      // First exp_done after LOAD wins; later strays must not disturb mul_b.
      if ((state_q != StIdle) && exp_done && !exp_ok_q) begin
         exp_ok_d = 1'b1;
         exp_d    = exp_result;
      end
      case (state_q)
         StIdle: begin
            if (go) begin
               m_d      = m;
               r_d      = r;
               n_d      = n;
               nsq_d    = exp_n;
               exp_ok_d = 1'b0;
`ifdef PAILLIER_RANGE_CHECK_EN
               err_d    = 1'b0;
`endif
               state_d  = StLoad;
            end
         end
         StLoad: begin
            acc_d = '0;
            if (range_bad) begin
               result_d = '0;
`ifdef PAILLIER_RANGE_CHECK_EN
               err_d    = 1'b1;
`endif
               state_d  = StDone;
            end else begin
               state_d = StGm;
            end
         end
         StGm: begin
            if (sam_done) begin
               acc_d   = sam_product + RSA_WIDTH'(1);
               state_d = StWaitExp;
            end
         end
         StWaitExp: begin
            if (exp_ok_q || exp_done) begin
               state_d = StMul;
            end
         end
         StMul:     state_d = StWaitMul;
         StWaitMul: begin
            if (mul_done) begin
               result_d = mul_result;
               state_d  = StDone;
            end
         end
         StDone:    state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   // State registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         m_q      <= '0;
         r_q      <= '0;
         n_q      <= '0;
         nsq_q    <= '0;
         acc_q    <= '0;
         exp_q    <= '0;
         exp_ok_q <= 1'b0;
         result_q <= '0;
`ifdef PAILLIER_RANGE_CHECK_EN
         err_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         m_q      <= m_d;
         r_q      <= r_d;
         n_q      <= n_d;
         nsq_q    <= nsq_d;
         acc_q    <= acc_d;
         exp_q    <= exp_d;
         exp_ok_q <= exp_ok_d;
         result_q <= result_d;
`ifdef PAILLIER_RANGE_CHECK_EN
         err_q    <= err_d;
`endif
      end
   end

   assign busy         = (state_q != StIdle);
   assign done         = (state_q == StDone);
   assign exp_go       = sam_start;
   assign mul_go       = (state_q == StMul);
   assign result       = result_q;
   assign exp_base     = {{(RSA_WIDTH-N_WIDTH){1'b0}}, r_q};
   assign exp_exponent = {{(RSA_WIDTH-N_WIDTH){1'b0}}, n_q};
   assign exp_modulus  = nsq_q;
   assign mul_a        = acc_q;
   assign mul_b        = exp_q;
   assign mul_modulus  = nsq_q;

endmodule

// File: tb/tb_paillier_encry_ctrl.sv
// Bench for paillier_encry_ctrl at RSA_WIDTH=16, N_WIDTH=8 with behavioural engines of
// programmable latency. Define PAILLIER_RANGE_CHECK_EN to exercise the err path too.
module tb_paillier_encry_ctrl;

   localparam int unsigned RW = 16;
   localparam int unsigned NW = 8;

   logic          clk = 1'b0;
   logic          rst_n, go;
   logic [NW-1:0] m, r, n;
   logic [RW-1:0] exp_n, result;
   logic          done, busy, exp_go, mul_go;
   logic [RW-1:0] exp_base, exp_exponent, exp_modulus, mul_a, mul_b, mul_modulus;
   logic          exp_done = 1'b0;
   logic          mul_done = 1'b0;
   logic [RW-1:0] exp_result = '0;
   logic [RW-1:0] mul_result = '0;
`ifdef PAILLIER_RANGE_CHECK_EN
   logic          err;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   paillier_encry_ctrl #(
      .RSA_WIDTH  (RW),
      .N_WIDTH    (NW),
      .DATA_WIDTH (128)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .go           (go),
      .m            (m),
      .r            (r),
      .n            (n),
      .exp_n        (exp_n),
      .result       (result),
      .done         (done),
      .busy         (busy),
`ifdef PAILLIER_RANGE_CHECK_EN
      .err          (err),
`endif
      .exp_go       (exp_go),
      .exp_base     (exp_base),
      .exp_exponent (exp_exponent),
      .exp_modulus  (exp_modulus),
      .exp_done     (exp_done),
      .exp_result   (exp_result),
      .mul_go       (mul_go),
      .mul_a        (mul_a),
      .mul_b        (mul_b),
      .mul_modulus  (mul_modulus),
      .mul_done     (mul_done),
      .mul_result   (mul_result)
   );

   function automatic int unsigned modexp(int unsigned b, int unsigned e, int unsigned md);
      int unsigned acc = 1;
      if (md == 0) return 0;
      for (int unsigned i = 0; i < e; i++) acc = (acc * (b % md)) % md;
      return acc % md;
   endfunction

   // Behavioural engines: not tied to rst_n, so a request in flight completes late.
   int unsigned exp_lat = 3, mul_lat = 3;
   int unsigned exp_cnt = 0, mul_cnt = 0;
   bit          exp_pend = 0, mul_pend = 0;
   logic [RW-1:0] eb, ee, em, ma, mb, mm;

   always @(posedge clk) begin
      exp_done <= 1'b0;
      if (exp_go) begin
         exp_pend <= 1'b1;
         exp_cnt  <= exp_lat;
         eb <= exp_base; ee <= exp_exponent; em <= exp_modulus;
      end else if (exp_pend) begin
         if (exp_cnt <= 1) begin
            exp_done   <= 1'b1;
            exp_result <= RW'(modexp(32'(eb), 32'(ee), 32'(em)));
            exp_pend   <= 1'b0;
         end else begin
            exp_cnt <= exp_cnt - 1;
         end
      end
   end

   always @(posedge clk) begin
      mul_done <= 1'b0;
      if (mul_go) begin
         mul_pend <= 1'b1;
         mul_cnt  <= mul_lat;
         ma <= mul_a; mb <= mul_b; mm <= mul_modulus;
      end else if (mul_pend) begin
         if (mul_cnt <= 1) begin
            mul_done   <= 1'b1;
            mul_result <= (mm == 0) ? '0 : RW'((32'(ma) * 32'(mb)) % 32'(mm));
            mul_pend   <= 1'b0;
         end else begin
            mul_cnt <= mul_cnt - 1;
         end
      end
   end

   // Pulse counters and operand snapshots taken at each handshake.
   int exp_go_n = 0, mul_go_n = 0, done_n = 0;
   logic [RW-1:0] last_mul_a = '0, last_exp_base = '0, last_exp_exp = '0;
   always @(posedge clk) begin
      if (exp_go) begin
         exp_go_n++;
         last_exp_base = exp_base;
         last_exp_exp  = exp_exponent;
      end
      if (mul_go) begin
         mul_go_n++;
         last_mul_a = mul_a;
      end
      if (done) done_n++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   typedef struct {
      logic [NW-1:0] m, r, n;
      logic [RW-1:0] nsq;
      int unsigned   exp_lat, mul_lat;
      logic [RW-1:0] exp_mul_a, exp_res;
   } vec_t;

   vec_t vecs[4];

   task automatic launch(input vec_t v);
      @(negedge clk);
      m = v.m; r = v.r; n = v.n; exp_n = v.nsq;
      exp_lat = v.exp_lat; mul_lat = v.mul_lat;
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
   endtask

   // Waits for done (bounded); cyc counts negedges since the go edge.
   task automatic wait_done(input string name, output int cyc);
      cyc = 1;
      while (done !== 1'b1 && cyc < 400) begin
         @(negedge clk);
         cyc++;
      end
      check({name, "_done_seen"}, 32'(done), 1);
   endtask

   initial begin
      int cyc, e0, mg0, d0;
      vecs[0] = '{8'd7, 8'd2, 8'd15, 16'd225, 3, 3, 16'd106, 16'd83};
      vecs[1] = '{8'd0, 8'd2, 8'd15, 16'd225, 3, 3, 16'd1, 16'd143};
      vecs[2] = '{8'd7, 8'd2, 8'd15, 16'd225, 2, 4, 16'd106, 16'd83};
      vecs[3] = '{8'd7, 8'd2, 8'd15, 16'd225, 40, 2, 16'd106, 16'd83};

      rst_n = 1'b0; go = 1'b0; m = '0; r = '0; n = '0; exp_n = '0;
      repeat (3) @(negedge clk);
      check("rst_result", 32'(result), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_exp_go", 32'(exp_go), 0);
      check("rst_mul_go", 32'(mul_go), 0);
      check("rst_mul_a", 32'(mul_a), 0);
`ifdef PAILLIER_RANGE_CHECK_EN
      check("rst_err", 32'(err), 0);
`endif
      rst_n = 1'b1;

      for (int i = 0; i < 4; i++) begin
         e0 = exp_go_n; mg0 = mul_go_n; d0 = done_n;
         launch(vecs[i]);
         check($sformatf("v%0d_busy", i), 32'(busy), 1);
         wait_done($sformatf("v%0d", i), cyc);
         check($sformatf("v%0d_result", i), 32'(result), 32'(vecs[i].exp_res));
         check($sformatf("v%0d_mul_a", i), 32'(last_mul_a), 32'(vecs[i].exp_mul_a));
`ifdef PAILLIER_RANGE_CHECK_EN
         check($sformatf("v%0d_err", i), 32'(err), 0);
`endif
         repeat (5) @(negedge clk);
         check($sformatf("v%0d_idle", i), 32'(busy), 0);
         check($sformatf("v%0d_hold", i), 32'(result), 32'(vecs[i].exp_res));
         check($sformatf("v%0d_exp_go_n", i), 32'(exp_go_n - e0), 1);
         check($sformatf("v%0d_mul_go_n", i), 32'(mul_go_n - mg0), 1);
         check($sformatf("v%0d_done_n", i), 32'(done_n - d0), 1);
      end
      check("exp_base", 32'(last_exp_base), 2);
      check("exp_exponent", 32'(last_exp_exp), 15);

      // Second go while waiting on modmul must be ignored.
      e0 = exp_go_n; mg0 = mul_go_n; d0 = done_n;
      begin
         vec_t v;
         v = vecs[0];
         v.mul_lat = 10;
         launch(v);
      end
      cyc = 0;
      while (mul_go_n == mg0 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check("busygo_mul_go_seen", 32'(mul_go_n - mg0), 1);
      @(negedge clk);
      @(negedge clk);
      m = 8'd0; go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      wait_done("busygo", cyc);
      check("busygo_result", 32'(result), 83);
      repeat (30) @(negedge clk);
      check("busygo_done_n", 32'(done_n - d0), 1);
      check("busygo_exp_go_n", 32'(exp_go_n - e0), 1);
      check("busygo_busy", 32'(busy), 0);

      // Reset in GM, then the abandoned modexp completes late.
      begin
         vec_t v;
         v = vecs[0];
         v.exp_lat = 40;
         launch(v);
      end
      repeat (3) @(negedge clk);
      d0 = done_n; mg0 = mul_go_n;
      rst_n = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 0);
      check("abort_result", 32'(result), 0);
      check("abort_mul_a", 32'(mul_a), 0);
      check("abort_exp_base", 32'(exp_base), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (50) @(negedge clk);
      check("abort_late_busy", 32'(busy), 0);
      check("abort_late_done_n", 32'(done_n - d0), 0);
      check("abort_late_mul_go_n", 32'(mul_go_n - mg0), 0);
      launch(vecs[0]);
      wait_done("fresh", cyc);
      check("fresh_result", 32'(result), 83);
      check("fresh_mul_a", 32'(last_mul_a), 106);

`ifdef PAILLIER_RANGE_CHECK_EN
      // m == n and r == 0 are rejected two cycles after go without touching the engines.
      for (int k = 0; k < 2; k++) begin
         vec_t v;
         v = vecs[0];
         if (k == 0) v.m = 8'd15;
         else        v.r = 8'd0;
         e0 = exp_go_n;
         launch(v);
         wait_done($sformatf("rc%0d", k), cyc);
         check($sformatf("rc%0d_latency", k), 32'(cyc), 2);
         check($sformatf("rc%0d_err", k), 32'(err), 1);
         check($sformatf("rc%0d_result", k), 32'(result), 0);
         repeat (3) @(negedge clk);
         check($sformatf("rc%0d_exp_go_n", k), 32'(exp_go_n - e0), 0);
      end
      launch(vecs[0]);
      check("rc_err_cleared", 32'(err), 0);
      wait_done("rc_after", cyc);
      check("rc_after_result", 32'(result), 83);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/paillier_encry_ctrl.md
Name: paillier_encry_ctrl

Overview:
Paillier encryption controller, the encrypt-side counterpart of the decryption top. Computes c = g^m · r^n mod n² with g = n+1, using the identity g^m mod n² = 1 + m·n.
- m·n is formed internally by a sequential shift-add.
- r^n mod n² is obtained from an external rsa4k-style modexp engine.
- The final product is obtained from an external modular-multiply engine, both through go/done handshakes.
- Sits beside the decryption top and shares the same engines.

Parameters:
RSA_WIDTH, 4096, width of n² and of ciphertext
N_WIDTH, RSA_WIDTH/2, width of n, m, r
DATA_WIDTH, 128, engine word width (passed through; not used internally)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
go  in  1  one-cycle start pulse
m  in  N_WIDTH  plaintext, m < n
r  in  N_WIDTH  random nonce, nonzero
n  in  N_WIDTH  public modulus
exp_n  in  RSA_WIDTH  n²
result  out  RSA_WIDTH  ciphertext c
done  out  1  one-cycle completion pulse
busy  out  1  high from accepted go until done
exp_go  out  1  modexp start pulse
exp_base  out  RSA_WIDTH  zero-extended r
exp_exponent  out  RSA_WIDTH  zero-extended n
exp_modulus  out  RSA_WIDTH  exp_n
exp_done  in  1  modexp done pulse
exp_result  in  RSA_WIDTH  r^n mod n²
mul_go  out  1  modmul start pulse
mul_a  out  RSA_WIDTH  g^m term
mul_b  out  RSA_WIDTH  captured r^n term
mul_modulus  out  RSA_WIDTH  exp_n
mul_done  in  1  modmul done pulse
mul_result  in  RSA_WIDTH  (a·b) mod n²

Behaviour:
- Reset: all outputs 0, FSM in IDLE, internal registers 0. Reset mid-operation aborts immediately. Engine done pulses arriving after reset are ignored in IDLE.
- Operands m, r, n, exp_n are captured on the accepted go. Inputs may change afterwards.
- go is accepted only in IDLE. go while busy is ignored.
- FSM:
  - IDLE –go→ LOAD.
  - LOAD (1 cycle): latch operands, pulse exp_go, clear acc, set bit counter to N_WIDTH-1 → GM.
  - GM: each cycle acc ← (acc<<1) + (m_reg[cnt] ? n_reg : 0), processing m MSB first.
    - exp_done is captured into a sticky exp_ok flag with exp_result latched; this may occur in any state from LOAD onward.
    - After N_WIDTH cycles (cnt = 0 processed), acc ← acc + 1 → WAIT_EXP.
  - WAIT_EXP: when exp_ok (or exp_done this cycle) → MUL.
  - MUL (1 cycle): pulse mul_go with mul_a = acc, mul_b = latched exp term → WAIT_MUL.
  - WAIT_MUL: on mul_done latch result → DONE.
  - DONE (1 cycle): done = 1 → IDLE.
- Width rules:
  - acc is RSA_WIDTH bits. Since m < n, 1 + m·n < n², so no reduction of acc is needed.
  - If m ≥ n, the behaviour without range check is undefined (engine output passed through).
- Engine operand outputs are held stable from LOAD/MUL until the corresponding done.
- busy = (state ≠ IDLE). result holds its value until the next done.
- Latency: max(N_WIDTH + 1, modexp latency) + modmul latency + ~4 cycles.

Optional Feature:
PAILLIER_RANGE_CHECK_EN
- Defined:
  - Adds output err (1 bit, reset 0).
  - In LOAD, if m ≥ n or r == 0: no exp_go is issued, the FSM jumps to DONE, result = 0, err = 1 with done.
  - err is cleared on the next accepted go.
- Undefined: no err port, no check; LOAD always proceeds to GM.

Decomposition:
- Shared package/include (_parameter.v): FSM state encodings, default widths.
- One natural sub-module: paillier_shift_add_mul, a sequential N_WIDTH×N_WIDTH shift-add multiplier with start/done. The controller then holds only the FSM and handshake logic.

Test Plan:
Bench parameters: RSA_WIDTH=16, N_WIDTH=8, with behavioural modexp/modmul models of programmable latency.
- n=15, exp_n=225, m=7, r=2 → exp_result 143, mul_a=106, result=83, single done pulse.
- m=0, same n/r → mul_a=1, result=143.
- Modexp latency 2 (done during GM) and latency 40 (done after GM) → both give result 83; exp_go and mul_go each pulse exactly once.
- Second go during WAIT_MUL → ignored; exactly one done; result is from the first request.
- rst_n low in GM, then a late exp_done → outputs 0, stays IDLE; a fresh request completes correctly.
- With PAILLIER_RANGE_CHECK_EN: m=15 with n=15, and separately r=0 → err=1, result=0, done 2 cycles after go, no exp_go.
